// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per frame, one bit per clock,
// with bit-valid and frame start/end strobes; back-to-back words stream without a gap.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_end_q, frame_end_d;
    logic               accept;
    logic [WIDTH-1:0]   sreg_shifted;

    // The output end of sreg always holds the bit on the wire; shifting fills with zeros.
    assign sreg_shifted = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]}
                                    : {sreg_q[WIDTH-2:0], 1'b0};

    assign load_ready = (state_q == IDLE) || (cnt_q == '0);
    assign accept     = load_valid && load_ready && !reset;

    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        cnt_d         = cnt_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = SHIFT;
                    sreg_d        = din;
                    cnt_d         = CNT_W'(WIDTH - 1);
                    frame_start_d = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    sreg_d      = sreg_shifted;
                    cnt_d       = cnt_q - CNT_W'(1);
                    frame_end_d = (cnt_q == CNT_W'(1));
                end else if (accept) begin
                    sreg_d        = din;
                    cnt_d         = CNT_W'(WIDTH - 1);
                    frame_start_d = 1'b1;
                end else begin
                    // Clearing sreg on the way out keeps sout low while idle.
                    state_d = IDLE;
                    sreg_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sreg_q        <= '0;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign sout        = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
    assign sout_valid  = (state_q == SHIFT);
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = sout_valid;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: three instances (W8 MSB-first, W8 LSB-first, W2 MSB-first)
// driven in parallel and compared each cycle against a queue-of-bits reference model.
module tb_piso_shift_tx;

    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic [7:0]    din;
    logic [NI-1:0] ready, sout, sval, fst, fend, busy;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(ready[0]), .sout(sout[0]), .sout_valid(sval[0]),
        .frame_start(fst[0]), .frame_end(fend[0]), .busy(busy[0]));

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(ready[1]), .sout(sout[1]), .sout_valid(sval[1]),
        .frame_start(fst[1]), .frame_end(fend[1]), .busy(busy[1]));

    piso_shift_tx #(.WIDTH(2), .LSB_FIRST(1'b0)) dut_w2 (
        .clk(clk), .reset(reset), .din(din[1:0]), .load_valid(load_valid),
        .load_ready(ready[2]), .sout(sout[2]), .sout_valid(sval[2]),
        .frame_start(fst[2]), .frame_end(fend[2]), .busy(busy[2]));

    // Reference: each queue holds the bits still to appear on the wire, head = current cycle.
    typedef struct packed {
        logic b;
        logic s;
        logic e;
    } ebit_t;

    ebit_t q [NI][$];
    int    w_of [NI];
    bit    lsb_of [NI];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            bit rdy;
            rdy = (q[k].size() <= 1);
            if (reset) begin
                q[k].delete();
            end else begin
                if (q[k].size() > 0) void'(q[k].pop_front());
                if (load_valid && rdy) begin
                    for (int i = 0; i < w_of[k]; i++) begin
                        ebit_t eb;
                        int    idx;
                        idx  = lsb_of[k] ? i : w_of[k] - 1 - i;
                        eb.b = din[idx];
                        eb.s = (i == 0);
                        eb.e = (i == w_of[k] - 1);
                        q[k].push_back(eb);
                    end
                end
            end
        end
    endtask

    // Packed as {sout, sout_valid, frame_start, frame_end, busy, load_ready}.
    function automatic logic [5:0] expected(input int k);
        if (q[k].size() == 0) return 6'b000001;
        return {q[k][0].b, 1'b1, q[k][0].s, q[k][0].e, 1'b1, logic'(q[k].size() <= 1)};
    endfunction

    // Called at a negedge: apply inputs, take one edge, check all instances at the next negedge.
    task automatic cycle(input logic r, input logic lv, input logic [7:0] d);
        reset      = r;
        load_valid = lv;
        din        = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check($sformatf("out%0d", k),
                  32'({sout[k], sval[k], fst[k], fend[k], busy[k], ready[k]}),
                  32'(expected(k)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        logic [7:0] cap_m, cap_l;
        int         hold_cnt, sval_cnt, rdy_cnt;
        bit         accepted;

        w_of   = '{8, 8, 2};
        lsb_of = '{1'b0, 1'b1, 1'b0};
        reset      = 1'b1;
        load_valid = 1'b0;
        din        = 8'h00;
        @(negedge clk);

        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        check("reset_state", 32'({sout, sval, fst, fend, busy, ready}), 32'({15'b0, 3'b111}));

        // Single word A5: MSB-first and LSB-first both read back as A5.
        cycle(1'b0, 1'b1, 8'hA5);
        cap_m = '0;
        cap_l = '0;
        for (int i = 0; i < 8; i++) begin
            cap_m    = {cap_m[6:0], sout[0]};
            cap_l[i] = sout[1];
            if (i < 7) cycle(1'b0, 1'b0, 8'h00);
        end
        check("a5_msb", 32'(cap_m), 32'h0000_00A5);
        check("a5_lsb", 32'(cap_l), 32'h0000_00A5);
        idle(2);
        check("a5_idle_after", 32'(sval[1:0]), 32'h0);

        // LSB-first with 01: first bit 1, then seven zeros.
        cycle(1'b0, 1'b1, 8'h01);
        cap_l = '0;
        for (int i = 0; i < 8; i++) begin
            cap_l = {cap_l[6:0], sout[1]};
            if (i < 7) cycle(1'b0, 1'b0, 8'h00);
        end
        check("lsb_01_wire_order", 32'(cap_l), 32'h0000_0080);
        idle(2);

        // Back-to-back F0 then 0F with load_valid held high.
        cycle(1'b0, 1'b1, 8'hF0);
        sval_cnt = int'(sval[0]);
        rdy_cnt  = int'(ready[0]);
        for (int j = 2; j <= 16; j++) begin
            cycle(1'b0, (j - 1 <= 8), 8'h0F);
            sval_cnt += int'(sval[0]);
            rdy_cnt  += int'(ready[0]);
        end
        check("b2b_valid_run", 32'(sval_cnt), 32'd16);
        check("b2b_ready_pulses", 32'(rdy_cnt), 32'd2);
        idle(3);

        // Busy-hold: request at the third bit, accepted only on the frame_end cycle.
        cycle(1'b0, 1'b1, 8'hA5);
        idle(2);
        hold_cnt = 0;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (ready[0]) accepted = 1'b1;
            else hold_cnt++;
            cycle(1'b0, 1'b1, 8'h3C);
        end
        check("hold_accepted", 32'(accepted), 32'd1);
        check("hold_cycles", 32'(hold_cnt), 32'd5);
        check("hold_zero_gap", 32'({sval[0], fst[0]}), 32'b11);
        idle(10);

        // Reset during bit 4 of FF, then a clean 81 frame.
        cycle(1'b0, 1'b1, 8'hFF);
        idle(3);
        cycle(1'b1, 1'b0, 8'h00);
        check("rst_mid", 32'({sout[0], sval[0], fst[0], fend[0], busy[0], ready[0]}), 32'h01);
        cycle(1'b0, 1'b1, 8'h81);
        cap_m = '0;
        for (int i = 0; i < 8; i++) begin
            cap_m = {cap_m[6:0], sout[0]};
            if (i < 7) cycle(1'b0, 1'b0, 8'h00);
        end
        check("post_rst_81", 32'(cap_m), 32'h0000_0081);
        idle(2);

        // Reset coincident with load_valid: word dropped.
        cycle(1'b1, 1'b1, 8'h55);
        check("rst_with_load", 32'(sval), 32'h0);
        cycle(1'b0, 1'b0, 8'h00);
        check("rst_with_load_next", 32'(sval), 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), 8'($urandom));
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
